// File: rtl/uart_instr_loader_pkg.sv
// Shared definitions for the UART instruction loader: state encoding and
// instruction-word constants.
package uart_instr_loader_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_HIGH = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   localparam int unsigned INSTR_WIDTH        = 16;
   localparam int unsigned DEFAULT_START_ADDR = 1;

endpackage

// File: rtl/idle_timer.sv
// Saturating idle counter with synchronous clear and enable; flags when the
// count has reached LIMIT.
module idle_timer #(
   parameter int unsigned      WIDTH = 32,
   parameter logic [WIDTH-1:0] LIMIT = WIDTH'(100000)
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   logic [WIDTH-1:0] count;

   // Clear has priority so a fresh byte always restarts the idle window.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (enable && (count != LIMIT)) begin
         count <= count + 1'b1;
      end
   end

   assign expired = (count == LIMIT);

endmodule

// File: rtl/uart_instr_loader.sv
// Pairs UART bytes into 16-bit instructions, writes them to consecutive
// instruction-memory addresses, and declares the load done after line idle.
module uart_instr_loader
   import uart_instr_loader_pkg::*;
#(
   parameter int unsigned           ADDR_WIDTH   = 8,
   parameter int unsigned           CNT_WIDTH    = 32,
   parameter logic [ADDR_WIDTH-1:0] START_ADDR   = ADDR_WIDTH'(DEFAULT_START_ADDR),
   parameter logic [CNT_WIDTH-1:0]  IDLE_TIMEOUT = CNT_WIDTH'(100000)
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   i_rx_valid,
   input  logic [7:0]             i_rx_data,
   output logic                   o_mem_wr_en,
   output logic [ADDR_WIDTH-1:0]  o_mem_addr,
   output logic [INSTR_WIDTH-1:0] o_mem_wdata,
   output logic                   o_transmit_done,
   output logic [ADDR_WIDTH-1:0]  o_max_addr_instr,
   output logic                   o_err_partial,
   output logic                   o_err_overflow
);

   state_t                state;
   logic [7:0]            high_byte;
   logic [ADDR_WIDTH-1:0] wr_ptr;
   logic [ADDR_WIDTH:0]   word_count;
   logic                  full;
   logic [ADDR_WIDTH-1:0] last_addr;
   logic                  timer_clear;
   logic                  timer_enable;
   logic                  timer_expired;

   // The idle window only runs once a word has landed, so the loader can wait
   // forever for the host to start sending.
   assign timer_clear  = i_rx_valid && (state != ST_DONE);
   assign timer_enable = (word_count != '0) && (state != ST_DONE);

   // Once the top address is written the pointer parks there instead of wrapping.
   assign last_addr = full ? '1 : (wr_ptr - 1'b1);

   idle_timer #(
      .WIDTH (CNT_WIDTH),
      .LIMIT (IDLE_TIMEOUT)
   ) u_idle_timer (
      .clk     (clk),
      .rst_n   (rst_n),
      .clear   (timer_clear),
      .enable  (timer_enable),
      .expired (timer_expired)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state            <= ST_IDLE;
         high_byte        <= '0;
         wr_ptr           <= START_ADDR;
         word_count       <= '0;
         full             <= 1'b0;
         o_mem_wr_en      <= 1'b0;
         o_mem_addr       <= START_ADDR;
         o_mem_wdata      <= '0;
         o_transmit_done  <= 1'b0;
         o_max_addr_instr <= '0;
         o_err_partial    <= 1'b0;
         o_err_overflow   <= 1'b0;
      end else begin
         o_mem_wr_en <= 1'b0;
         unique case (state)
            ST_IDLE: begin
               if (i_rx_valid) begin
                  high_byte <= i_rx_data;
                  state     <= ST_HIGH;
               end else if (timer_expired) begin
                  state            <= ST_DONE;
                  o_transmit_done  <= 1'b1;
                  o_max_addr_instr <= last_addr;
               end
            end
            ST_HIGH: begin
               // A byte arriving on the timeout cycle still wins over the timeout.
               if (i_rx_valid) begin
                  state <= ST_IDLE;
                  if (full) begin
                     o_err_overflow <= 1'b1;
                  end else begin
                     o_mem_wr_en <= 1'b1;
                     o_mem_addr  <= wr_ptr;
                     o_mem_wdata <= {high_byte, i_rx_data};
                     word_count  <= word_count + 1'b1;
                     if (wr_ptr == '1) begin
                        full <= 1'b1;
                     end else begin
                        wr_ptr <= wr_ptr + 1'b1;
                     end
                  end
               end else if (timer_expired) begin
                  state            <= ST_DONE;
                  o_transmit_done  <= 1'b1;
                  o_max_addr_instr <= last_addr;
                  o_err_partial    <= 1'b1;
               end
            end
            ST_DONE: begin
               state <= ST_DONE;
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_instr_loader.sv
// Scoreboard bench for uart_instr_loader: directed byte streams, expected
// writes queued by stimulus and checked by independent monitors.
module tb_uart_instr_loader;

   localparam int TIMEOUT = 40;

   typedef struct {
      logic [7:0]  addr;
      logic [15:0] data;
      int          cyc;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        rx_valid;
   logic [7:0]  rx_data;
   logic        sel;
   logic        rx_valid_a;
   logic        rx_valid_b;

   logic        wr_en_a, done_a, partial_a, overflow_a;
   logic [7:0]  addr_a, max_a;
   logic [15:0] wdata_a;
   logic        wr_en_b, done_b, partial_b, overflow_b;
   logic [2:0]  addr_b, max_b;
   logic [15:0] wdata_b;

   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   exp_t q_a[$];
   exp_t q_b[$];
   exp_t got_a, got_b;
   logic prev_wr_a = 1'b0;
   logic prev_wr_b = 1'b0;
   logic [15:0] prog [11] = '{16'h4126, 16'h8180, 16'h1234, 16'h5678, 16'h9ABC, 16'hDEF0,
                              16'h0F0F, 16'hA5A5, 16'h3C3C, 16'h7001, 16'hE000};

   assign rx_valid_a = rx_valid & ~sel;
   assign rx_valid_b = rx_valid & sel;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   uart_instr_loader #(
      .ADDR_WIDTH   (8),
      .CNT_WIDTH    (32),
      .START_ADDR   (8'd1),
      .IDLE_TIMEOUT (32'(TIMEOUT))
   ) dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .i_rx_valid       (rx_valid_a),
      .i_rx_data        (rx_data),
      .o_mem_wr_en      (wr_en_a),
      .o_mem_addr       (addr_a),
      .o_mem_wdata      (wdata_a),
      .o_transmit_done  (done_a),
      .o_max_addr_instr (max_a),
      .o_err_partial    (partial_a),
      .o_err_overflow   (overflow_a)
   );

   uart_instr_loader #(
      .ADDR_WIDTH   (3),
      .CNT_WIDTH    (32),
      .START_ADDR   (3'd1),
      .IDLE_TIMEOUT (32'(TIMEOUT))
   ) dut_small (
      .clk              (clk),
      .rst_n            (rst_n),
      .i_rx_valid       (rx_valid_b),
      .i_rx_data        (rx_data),
      .o_mem_wr_en      (wr_en_b),
      .o_mem_addr       (addr_b),
      .o_mem_wdata      (wdata_b),
      .o_transmit_done  (done_b),
      .o_max_addr_instr (max_b),
      .o_err_partial    (partial_b),
      .o_err_overflow   (overflow_b)
   );

   // Monitors: every write must match the head of its queue, on its due cycle.
   always @(negedge clk) begin
      if (wr_en_a) begin
         checks++;
         if (prev_wr_a) begin
            errors++;
            $display("[TB] FAIL wr_a_back_to_back: wr_en high two cycles running, required single-cycle strobe");
         end else if (q_a.size() == 0) begin
            errors++;
            $display("[TB] FAIL write_a_unexpected: got addr=%0d data=%h, required no write", addr_a, wdata_a);
         end else begin
            got_a = q_a.pop_front();
            if (addr_a !== got_a.addr || wdata_a !== got_a.data || cyc != got_a.cyc) begin
               errors++;
               $display("[TB] FAIL write_a: got addr=%0d data=%h cyc=%0d, required addr=%0d data=%h cyc=%0d",
                        addr_a, wdata_a, cyc, got_a.addr, got_a.data, got_a.cyc);
            end
         end
      end
      if (q_a.size() != 0 && q_a[0].cyc < cyc) begin
         checks++;
         errors++;
         got_a = q_a.pop_front();
         $display("[TB] FAIL write_a_missing: no write seen, required addr=%0d data=%h", got_a.addr, got_a.data);
      end
      prev_wr_a <= wr_en_a;
   end

   always @(negedge clk) begin
      if (wr_en_b) begin
         checks++;
         if (prev_wr_b) begin
            errors++;
            $display("[TB] FAIL wr_b_back_to_back: wr_en high two cycles running, required single-cycle strobe");
         end else if (q_b.size() == 0) begin
            errors++;
            $display("[TB] FAIL write_b_unexpected: got addr=%0d data=%h, required no write", addr_b, wdata_b);
         end else begin
            got_b = q_b.pop_front();
            if ({5'b0, addr_b} !== got_b.addr || wdata_b !== got_b.data || cyc != got_b.cyc) begin
               errors++;
               $display("[TB] FAIL write_b: got addr=%0d data=%h cyc=%0d, required addr=%0d data=%h cyc=%0d",
                        addr_b, wdata_b, cyc, got_b.addr, got_b.data, got_b.cyc);
            end
         end
      end
      if (q_b.size() != 0 && q_b[0].cyc < cyc) begin
         checks++;
         errors++;
         got_b = q_b.pop_front();
         $display("[TB] FAIL write_b_missing: no write seen, required addr=%0d data=%h", got_b.addr, got_b.data);
      end
      prev_wr_b <= wr_en_b;
   end

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0h, required %0h", name, actual, expected);
      end
   endtask

   task automatic idleCycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Drives one byte strobe; when push is set the byte completes a word whose
   // write must appear exactly one cycle later.
   task automatic applyStimulus(input logic [7:0] b, input bit push, input int addr, input logic [15:0] word);
      exp_t e;
      @(negedge clk);
      if (push) begin
         e.addr = 8'(addr);
         e.data = word;
         e.cyc  = cyc + 1;
         if (sel) q_b.push_back(e);
         else     q_a.push_back(e);
      end
      rx_data  = b;
      rx_valid = 1'b1;
      @(negedge clk);
      rx_valid = 1'b0;
   endtask

   task automatic doReset();
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   // Called right after the last byte strobe: done must rise TIMEOUT+1 cycles later.
   task automatic expectTimeout(input int max_addr, input bit partial);
      idleCycles(TIMEOUT);
      checkOutput("done_before_timeout", 32'(sel ? done_b : done_a), 32'd0);
      idleCycles(1);
      checkOutput("done_at_timeout", 32'(sel ? done_b : done_a), 32'd1);
      checkOutput("max_addr_instr", sel ? {29'b0, max_b} : {24'b0, max_a}, 32'(max_addr));
      checkOutput("err_partial", 32'(sel ? partial_b : partial_a), 32'(partial));
   endtask

   initial begin
      rst_n    = 1'b0;
      rx_valid = 1'b0;
      rx_data  = 8'h00;
      sel      = 1'b0;
      idleCycles(3);
      rst_n = 1'b1;
      idleCycles(1);

      checkOutput("reset_wr_en", 32'(wr_en_a), 32'd0);
      checkOutput("reset_addr", 32'(addr_a), 32'd1);
      checkOutput("reset_wdata", 32'(wdata_a), 32'd0);
      checkOutput("reset_done", 32'(done_a), 32'd0);
      checkOutput("reset_max_addr", 32'(max_a), 32'd0);
      checkOutput("reset_partial", 32'(partial_a), 32'd0);
      checkOutput("reset_overflow", 32'(overflow_a), 32'd0);
      checkOutput("reset_small_addr", 32'(addr_b), 32'd1);

      // Two-word program, then idle.
      applyStimulus(8'h41, 1'b0, 0, 16'h0);
      idleCycles(5);
      applyStimulus(8'h26, 1'b1, 1, 16'h4126);
      idleCycles(5);
      applyStimulus(8'h81, 1'b0, 0, 16'h0);
      idleCycles(5);
      applyStimulus(8'h80, 1'b1, 2, 16'h8180);
      expectTimeout(2, 1'b0);
      checkOutput("overflow_two_words", 32'(overflow_a), 32'd0);

      // Bytes after done are ignored.
      applyStimulus(8'h41, 1'b0, 0, 16'h0);
      idleCycles(3);
      applyStimulus(8'h00, 1'b0, 0, 16'h0);
      idleCycles(3);
      checkOutput("done_holds", 32'(done_a), 32'd1);
      checkOutput("max_addr_holds", 32'(max_a), 32'd2);

      // Reset then reload, ending on an odd trailing byte.
      doReset();
      checkOutput("rst_done_cleared", 32'(done_a), 32'd0);
      checkOutput("rst_addr_restored", 32'(addr_a), 32'd1);
      applyStimulus(8'h41, 1'b0, 0, 16'h0);
      idleCycles(5);
      applyStimulus(8'h00, 1'b1, 1, 16'h4100);
      idleCycles(5);
      checkOutput("reload_done_low", 32'(done_a), 32'd0);
      applyStimulus(8'h81, 1'b0, 0, 16'h0);
      expectTimeout(1, 1'b1);

      // Eleven-word program with bytes spaced just under the timeout.
      doReset();
      for (int i = 0; i < 11; i++) begin
         applyStimulus(prog[i][15:8], 1'b0, 0, 16'h0);
         idleCycles(30);
         applyStimulus(prog[i][7:0], 1'b1, i + 1, prog[i]);
         if (i != 10) idleCycles(30);
      end
      expectTimeout(11, 1'b0);

      // Byte strobe landing exactly on the timeout cycle.
      doReset();
      applyStimulus(8'h41, 1'b0, 0, 16'h0);
      idleCycles(5);
      applyStimulus(8'h26, 1'b1, 1, 16'h4126);
      idleCycles(TIMEOUT - 1);
      applyStimulus(8'h12, 1'b0, 0, 16'h0);
      checkOutput("collision_not_done", 32'(done_a), 32'd0);
      idleCycles(10);
      applyStimulus(8'h34, 1'b1, 2, 16'h1234);
      expectTimeout(2, 1'b0);

      // Small address space: eight words, the eighth overflows.
      sel = 1'b1;
      doReset();
      for (int w = 0; w < 8; w++) begin
         if (w == 7) checkOutput("overflow_before_full", 32'(overflow_b), 32'd0);
         applyStimulus(8'h10 + 8'(w), 1'b0, 0, 16'h0);
         idleCycles(3);
         applyStimulus(8'(w), (w < 7), w + 1, {8'h10 + 8'(w), 8'(w)});
         if (w != 7) idleCycles(3);
      end
      expectTimeout(7, 1'b0);
      checkOutput("overflow_sticky", 32'(overflow_b), 32'd1);

      idleCycles(3);
      checkOutput("queue_a_drained", 32'(q_a.size()), 32'd0);
      checkOutput("queue_b_drained", 32'(q_b.size()), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
